// File: rtl/scr1_dmem_router_mp.sv
// rtl/scr1_dmem_router_mp.sv - in-order data-memory router from one core port to NPORTS targets
// Responses return in issue order; a new target is only opened once all older requests have drained.
module scr1_dmem_router_mp #(
    parameter int                    NPORTS       = 4,
    parameter int                    OUTST        = 2,
    parameter logic [32*NPORTS-1:0]  PORT_MASK    = {NPORTS{32'hFFFF0000}},
    parameter logic [32*NPORTS-1:0]  PORT_PATTERN = {32'h00030000, 32'h00020000, 32'h00010000, 32'h0},
    parameter bit                    NULL_ERR_EN  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dmem_req,
    output logic                   dmem_req_ack,
    input  logic                   dmem_cmd,
    input  logic [1:0]             dmem_width,
    input  logic [31:0]            dmem_addr,
    input  logic [31:0]            dmem_wdata,
    output logic [31:0]            dmem_rdata,
    output logic [1:0]             dmem_resp,
    output logic [NPORTS-1:0]      port_req,
    input  logic [NPORTS-1:0]      port_req_ack,
    output logic [NPORTS-1:0]      port_cmd,
    output logic [2*NPORTS-1:0]    port_width,
    output logic [32*NPORTS-1:0]   port_addr,
    output logic [32*NPORTS-1:0]   port_wdata,
    input  logic [32*NPORTS-1:0]   port_rdata,
    input  logic [2*NPORTS-1:0]    port_resp,
    output logic                   busy
);
    localparam logic [1:0] RESP_IDLE   = 2'd0;
    localparam logic [1:0] RESP_RDY_OK = 2'd1;
    localparam logic [1:0] RESP_RDY_ER = 2'd2;

    localparam int IDW = $clog2(NPORTS + 1);
    localparam int PW  = (OUTST > 1) ? $clog2(OUTST) : 1;
    localparam int CW  = $clog2(OUTST + 1);
    // The extra ID past the last port marks a request that decoded to no target.
    localparam logic [IDW-1:0] ID_INV = IDW'(NPORTS);

    logic [IDW-1:0] fifo [OUTST];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic [IDW-1:0] tail_id;

    logic [IDW-1:0] sel_id;
    logic [IDW-1:0] head_id;
    logic [1:0]     head_resp;
    logic [31:0]    head_rdata;
    logic           sel_inv;
    logic           sel_ack;
    logic           pop;
    logic [CW-1:0]  cnt_after;
    logic           cap_ok;
    logic           order_ok;
    logic           go;
    logic           accept;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTST - 1)) ? '0 : p + PW'(1);
    endfunction

    // Walk downwards so the lowest matching port index wins.
    always_comb begin
        sel_id = (NULL_ERR_EN && dmem_addr == 32'h0) ? ID_INV : '0;
        for (int i = NPORTS - 1; i >= 1; i--) begin
            if ((dmem_addr & PORT_MASK[32*i +: 32]) == PORT_PATTERN[32*i +: 32])
                sel_id = IDW'(i);
        end
    end

    assign head_id = fifo[rd_ptr];

    always_comb begin
        head_resp  = RESP_IDLE;
        head_rdata = 32'h0;
        if (count != '0) begin
            if (head_id == ID_INV) begin
                head_resp  = RESP_RDY_ER;
                head_rdata = 32'hBADBADBA;
            end else begin
                for (int i = 0; i < NPORTS; i++) begin
                    if (head_id == IDW'(i)) begin
                        head_resp  = port_resp[2*i +: 2];
                        head_rdata = port_rdata[32*i +: 32];
                    end
                end
            end
        end
    end

    assign pop       = !rst && (count != '0) && (head_resp != RESP_IDLE);
    assign cnt_after = count - CW'(pop);
    assign cap_ok    = 32'(cnt_after) < OUTST;
    assign order_ok  = (cnt_after == '0) || (sel_id == tail_id);
    assign go        = !rst && dmem_req && cap_ok && order_ok;
    assign sel_inv   = (sel_id == ID_INV);

    always_comb begin
        sel_ack = sel_inv;
        for (int i = 0; i < NPORTS; i++) begin
            port_req[i] = go && !sel_inv && (sel_id == IDW'(i));
            if (sel_id == IDW'(i))
                sel_ack = port_req_ack[i];
        end
    end

    assign accept       = go && sel_ack;
    assign dmem_req_ack = accept;
    assign dmem_resp    = rst ? RESP_IDLE : head_resp;
    assign dmem_rdata   = rst ? 32'h0 : head_rdata;
    assign busy         = !rst && (count != '0);

    assign port_cmd   = {NPORTS{dmem_cmd}};
    assign port_width = {NPORTS{dmem_width}};
    assign port_addr  = {NPORTS{dmem_addr}};
    assign port_wdata = {NPORTS{dmem_wdata}};

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            tail_id <= '0;
        end else begin
            if (accept) begin
                wr_ptr  <= ptr_inc(wr_ptr);
                tail_id <= sel_id;
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(accept) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            fifo[wr_ptr] <= sel_id;
    end
endmodule

// File: tb/tb_scr1_dmem_router_mp.sv
// tb/tb_scr1_dmem_router_mp.sv - scoreboard bench for scr1_dmem_router_mp
module tb_scr1_dmem_router_mp;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OK   = 2'd1;
    localparam logic [1:0] ER   = 2'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic          dmem_req;
    logic          dmem_req_ack;
    logic          dmem_cmd;
    logic [1:0]    dmem_width;
    logic [31:0]   dmem_addr;
    logic [31:0]   dmem_wdata;
    logic [31:0]   dmem_rdata;
    logic [1:0]    dmem_resp;
    logic [3:0]    port_req;
    logic [3:0]    port_req_ack;
    logic [3:0]    port_cmd;
    logic [7:0]    port_width;
    logic [127:0]  port_addr;
    logic [127:0]  port_wdata;
    logic [127:0]  port_rdata;
    logic [7:0]    port_resp;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;
    logic [33:0] sb [$];
    logic [33:0] pend_exp;

    always #5 clk = ~clk;

    scr1_dmem_router_mp dut (
        .clk(clk), .rst(rst),
        .dmem_req(dmem_req), .dmem_req_ack(dmem_req_ack),
        .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .port_req(port_req), .port_req_ack(port_req_ack),
        .port_cmd(port_cmd), .port_width(port_width),
        .port_addr(port_addr), .port_wdata(port_wdata),
        .port_rdata(port_rdata), .port_resp(port_resp),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_resp(input int p, input logic [1:0] r, input logic [31:0] d);
        port_resp[2*p +: 2]   = r;
        port_rdata[32*p +: 32] = d;
    endtask

    // Sample mid-cycle: retire a response against the queue head, then record any accept.
    task automatic mon();
        logic [33:0] e;
        @(negedge clk);
        if (rst) begin
            sb.delete();
        end else begin
            if (dmem_resp != IDLE) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(dmem_resp), 32'(IDLE));
                end else begin
                    e = sb.pop_front();
                    chk("sb_resp", 32'(dmem_resp), 32'(e[33:32]));
                    chk("sb_rdata", dmem_rdata, e[31:0]);
                end
            end
            if (dmem_req && dmem_req_ack)
                sb.push_back(pend_exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'd2;
        dmem_addr = 32'h00010004; dmem_wdata = 32'h0;
        port_req_ack = 4'hF; port_rdata = '0; port_resp = '0; pend_exp = '0;
        nxt();
        mon();
        chk("rst_ack", 32'(dmem_req_ack), 32'd0);
        chk("rst_preq", 32'(port_req), 32'd0);
        chk("rst_resp", 32'(dmem_resp), 32'(IDLE));
        chk("rst_rdata", dmem_rdata, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        nxt();
        rst = 1'b0; dmem_req = 1'b0;
        mon(); nxt();

        // Single read to port 1
        dmem_req = 1'b1; dmem_addr = 32'h00010004; port_req_ack = 4'b0010;
        pend_exp = {OK, 32'h00001234};
        mon();
        chk("t1_preq", 32'(port_req), 32'b0010);
        chk("t1_ack", 32'(dmem_req_ack), 32'd1);
        chk("t1_no_same_cycle_resp", 32'(dmem_resp), 32'(IDLE));
        nxt();
        dmem_req = 1'b0; set_resp(1, OK, 32'h00001234);
        mon();
        chk("t1_busy_hold", 32'(busy), 32'd1);
        nxt();
        set_resp(1, IDLE, 32'h0);
        mon();
        chk("t1_busy_fall", 32'(busy), 32'd0);
        nxt();

        // Capacity stall with OUTST=2 on port 2
        dmem_req = 1'b1; dmem_addr = 32'h00020000; port_req_ack = 4'b0100;
        pend_exp = {OK, 32'hA0000001};
        mon(); chk("t2_ack0", 32'(dmem_req_ack), 32'd1); nxt();
        dmem_addr = 32'h00020004; pend_exp = {OK, 32'hA0000002};
        mon(); chk("t2_ack1", 32'(dmem_req_ack), 32'd1); nxt();
        dmem_addr = 32'h00020008; pend_exp = {OK, 32'hA0000003};
        for (int i = 0; i < 2; i++) begin
            mon();
            chk("t2_stall_ack", 32'(dmem_req_ack), 32'd0);
            chk("t2_stall_preq", 32'(port_req), 32'd0);
            nxt();
        end
        set_resp(2, OK, 32'hA0000001);
        mon();
        chk("t2_pop_accept_ack", 32'(dmem_req_ack), 32'd1);
        chk("t2_pop_accept_preq", 32'(port_req), 32'b0100);
        nxt();
        dmem_req = 1'b0; set_resp(2, OK, 32'hA0000002);
        mon(); nxt();
        set_resp(2, OK, 32'hA0000003);
        mon(); nxt();
        set_resp(2, IDLE, 32'h0);
        mon(); chk("t2_busy_end", 32'(busy), 32'd0); nxt();

        // Target switch waits for drain
        dmem_req = 1'b1; dmem_addr = 32'h00010000; port_req_ack = 4'b0110;
        pend_exp = {OK, 32'hB0000001};
        mon(); chk("t3_ack_p1", 32'(dmem_req_ack), 32'd1); nxt();
        dmem_addr = 32'h00020000; pend_exp = {OK, 32'hB0000002};
        for (int i = 0; i < 2; i++) begin
            mon();
            chk("t3_block_ack", 32'(dmem_req_ack), 32'd0);
            chk("t3_block_preq", 32'(port_req), 32'd0);
            nxt();
        end
        set_resp(1, OK, 32'hB0000001);
        mon();
        chk("t3_switch_ack", 32'(dmem_req_ack), 32'd1);
        chk("t3_switch_preq", 32'(port_req), 32'b0100);
        nxt();
        dmem_req = 1'b0; set_resp(1, IDLE, 32'h0); set_resp(2, OK, 32'hB0000002);
        mon(); nxt();
        set_resp(2, IDLE, 32'h0);
        mon(); chk("t3_busy_end", 32'(busy), 32'd0); nxt();

        // Null address decodes invalid
        dmem_req = 1'b1; dmem_addr = 32'h0; port_req_ack = 4'b0000;
        pend_exp = {ER, 32'hBADBADBA};
        mon();
        chk("t4_ack", 32'(dmem_req_ack), 32'd1);
        chk("t4_preq", 32'(port_req), 32'd0);
        chk("t4_latency", 32'(dmem_resp), 32'(IDLE));
        nxt();
        dmem_req = 1'b0;
        mon(); chk("t4_err_resp", 32'(dmem_resp), 32'(ER)); nxt();
        mon(); chk("t4_busy_end", 32'(busy), 32'd0); nxt();

        // Default port 0, error then normal completion
        dmem_req = 1'b1; dmem_addr = 32'h00050000; port_req_ack = 4'b0001;
        pend_exp = {ER, 32'hC0000001};
        mon();
        chk("t5_preq", 32'(port_req), 32'b0001);
        chk("t5_ack0", 32'(dmem_req_ack), 32'd1);
        nxt();
        dmem_addr = 32'h00050004; pend_exp = {OK, 32'hC0000002};
        mon(); chk("t5_ack1", 32'(dmem_req_ack), 32'd1); nxt();
        dmem_req = 1'b0; set_resp(0, ER, 32'hC0000001);
        mon(); nxt();
        set_resp(0, OK, 32'hC0000002);
        mon(); nxt();
        set_resp(0, IDLE, 32'h0);
        mon(); chk("t5_busy_end", 32'(busy), 32'd0); nxt();

        // Stray response while empty is ignored
        set_resp(3, OK, 32'hEEEE0000);
        mon(); chk("t6_idle_ignore", 32'(dmem_resp), 32'(IDLE)); nxt();
        set_resp(3, IDLE, 32'h0);

        // Reset with two outstanding discards tags
        dmem_req = 1'b1; dmem_addr = 32'h00010000; port_req_ack = 4'b0010;
        pend_exp = {OK, 32'hD0000001};
        mon(); chk("t7_ack0", 32'(dmem_req_ack), 32'd1); nxt();
        pend_exp = {OK, 32'hD0000002};
        mon(); chk("t7_ack1", 32'(dmem_req_ack), 32'd1); nxt();
        dmem_req = 1'b0; rst = 1'b1;
        mon();
        chk("t7_rst_resp", 32'(dmem_resp), 32'(IDLE));
        chk("t7_rst_busy", 32'(busy), 32'd0);
        nxt();
        rst = 1'b0; set_resp(1, OK, 32'hD0000001);
        mon();
        chk("t7_post_resp", 32'(dmem_resp), 32'(IDLE));
        chk("t7_post_rdata", dmem_rdata, 32'h0);
        chk("t7_post_busy", 32'(busy), 32'd0);
        nxt();
        set_resp(1, IDLE, 32'h0);
        mon(); nxt();

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
